// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, data width and the byte-strobe merge helper.
package axil_pkg;

    localparam int AXIL_DATA_W = 32;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    function automatic logic [AXIL_DATA_W-1:0] strb_merge(
        input logic [AXIL_DATA_W-1:0]   old_v,
        input logic [AXIL_DATA_W-1:0]   new_v,
        input logic [AXIL_DATA_W/8-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] merged;
        merged = old_v;
        for (int k = 0; k < AXIL_DATA_W/8; k++) begin
            if (strb[k]) begin
                merged[8*k +: 8] = new_v[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_skid_hold.sv
// One-entry holding slot for an AXI4-Lite request channel: accepts a payload when empty,
// keeps it until the consumer clears it, and drives a registered ready.
module axil_skid_hold #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         clr_i,
    output logic         ready_o,
    output logic         held_o,
    output logic [W-1:0] data_o
);

    logic         held_q;
    logic         held_d;
    logic         ready_q;
    logic         ready_d;
    logic [W-1:0] data_q;
    logic         accept;

    assign accept = valid_i && ready_q;

    // clr_i only fires while held, when ready is low, so it never races an accept.
    always_comb begin
        held_d = held_q;
        if (clr_i) begin
            held_d = 1'b0;
        end else if (accept) begin
            held_d = 1'b1;
        end
        ready_d = !held_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            held_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            held_q  <= held_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            data_q <= data_i;
        end
    end

    assign ready_o = ready_q;
    assign held_o  = held_q;
    assign data_o  = data_q;

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave with NUM_REGS 32-bit registers driven out in parallel on regOut.
// Define AXIL_REG_WR_PULSE_EN to add the per-register wrPulse output.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDR_W-1:0]        awAddr,
    input  logic [2:0]               awProt,
    input  logic                     awValid,
    output logic                     awReady,
    input  logic [31:0]              wData,
    input  logic [3:0]               wStrb,
    input  logic                     wValid,
    output logic                     wReady,
    output logic [1:0]               bResp,
    output logic                     bValid,
    input  logic                     bReady,
    input  logic [ADDR_W-1:0]        arAddr,
    input  logic [2:0]               arProt,
    input  logic                     arValid,
    output logic                     arReady,
    output logic [31:0]              rData,
    output logic [1:0]               rResp,
    output logic                     rValid,
    input  logic                     rReady,
`ifdef AXIL_REG_WR_PULSE_EN
    output logic [NUM_REGS-1:0]      wrPulse,
`endif
    output logic [NUM_REGS*32-1:0]   regOut
);

    localparam logic [31:0] NREGS = 32'(NUM_REGS);

    logic                     aw_held;
    logic                     w_held;
    logic [ADDR_W-1:0]        aw_addr;
    logic [AXIL_DATA_W+3:0]   w_payload;
    logic [AXIL_DATA_W-1:0]   w_data;
    logic [3:0]               w_strb;
    logic                     commit;
    logic [31:0]              wr_idx;
    logic                     wr_in_range;

    logic [AXIL_DATA_W-1:0]   regs_q [NUM_REGS];
    logic [AXIL_DATA_W-1:0]   regs_d [NUM_REGS];

    logic                     bvalid_q;
    logic                     bvalid_d;
    resp_t                    bresp_q;
    resp_t                    bresp_d;

    logic                     rd_en_q;
    logic                     ar_hs;
    logic [31:0]              rd_idx;
    logic                     rd_in_range;
    logic [AXIL_DATA_W-1:0]   rd_word;
    logic                     rvalid_q;
    logic                     rvalid_d;
    logic [AXIL_DATA_W-1:0]   rdata_q;
    logic [AXIL_DATA_W-1:0]   rdata_d;
    resp_t                    rresp_q;
    resp_t                    rresp_d;

    logic                     unused_ok;

    axil_skid_hold #(.W(ADDR_W)) u_aw_hold (
        .clk_i   (aclk),
        .rst_i   (areset),
        .valid_i (awValid),
        .data_i  (awAddr),
        .clr_i   (commit),
        .ready_o (awReady),
        .held_o  (aw_held),
        .data_o  (aw_addr)
    );

    axil_skid_hold #(.W(AXIL_DATA_W + 4)) u_w_hold (
        .clk_i   (aclk),
        .rst_i   (areset),
        .valid_i (wValid),
        .data_i  ({wStrb, wData}),
        .clr_i   (commit),
        .ready_o (wReady),
        .held_o  (w_held),
        .data_o  (w_payload)
    );

    assign w_data      = w_payload[AXIL_DATA_W-1:0];
    assign w_strb      = w_payload[AXIL_DATA_W+3:AXIL_DATA_W];
    assign wr_idx      = 32'(aw_addr[ADDR_W-1:2]);
    assign wr_in_range = wr_idx < NREGS;
    assign commit      = aw_held && w_held && (!bvalid_q || bReady);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && wr_in_range && (wr_idx == 32'(i))) begin
                regs_d[i] = strb_merge(regs_q[i], w_data, w_strb);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // A new commit may land in the same cycle the previous response is taken.
    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (bReady) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    // rd_en_q keeps arReady low while reset is asserted and for the release edge.
    assign arReady     = rd_en_q && (!rvalid_q || rReady);
    assign ar_hs       = arValid && arReady;
    assign rd_idx      = 32'(arAddr[ADDR_W-1:2]);
    assign rd_in_range = rd_idx < NREGS;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 32'(i)) begin
                rd_word = regs_q[i];
            end
        end
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range ? rd_word : '0;
            rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rReady) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_en_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_en_q  <= 1'b1;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

`ifdef AXIL_REG_WR_PULSE_EN
    logic [NUM_REGS-1:0] pulse_q;
    logic [NUM_REGS-1:0] pulse_d;

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pulse_d[i] = commit && wr_in_range && (wr_idx == 32'(i)) && (|w_strb);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign wrPulse = pulse_q;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regout
        assign regOut[32*g +: 32] = regs_q[g];
    end

    assign bValid  = bvalid_q;
    assign bResp   = bresp_q;
    assign rValid  = rvalid_q;
    assign rData   = rdata_q;
    assign rResp   = rresp_q;

    assign unused_ok = ^{awProt, arProt, aw_addr[1:0], arAddr[1:0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave with a queue-based transaction model checked every cycle.
`timescale 1ns/1ps
module tb_axil_reg_slave;

    localparam int          ADDR_W    = 12;
    localparam int          NUM_REGS  = 16;
    localparam logic [31:0] RESET_VAL = 32'h0;

    logic                   aclk = 1'b0;
    logic                   areset;
    logic [ADDR_W-1:0]      awAddr;
    logic [2:0]             awProt;
    logic                   awValid;
    logic                   awReady;
    logic [31:0]            wData;
    logic [3:0]             wStrb;
    logic                   wValid;
    logic                   wReady;
    logic [1:0]             bResp;
    logic                   bValid;
    logic                   bReady;
    logic [ADDR_W-1:0]      arAddr;
    logic [2:0]             arProt;
    logic                   arValid;
    logic                   arReady;
    logic [31:0]            rData;
    logic [1:0]             rResp;
    logic                   rValid;
    logic                   rReady;
    logic [NUM_REGS*32-1:0] regOut;
`ifdef AXIL_REG_WR_PULSE_EN
    logic [NUM_REGS-1:0]    wrPulse;
`endif

    always #5 aclk = ~aclk;

    axil_reg_slave #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .awAddr  (awAddr),
        .awProt  (awProt),
        .awValid (awValid),
        .awReady (awReady),
        .wData   (wData),
        .wStrb   (wStrb),
        .wValid  (wValid),
        .wReady  (wReady),
        .bResp   (bResp),
        .bValid  (bValid),
        .bReady  (bReady),
        .arAddr  (arAddr),
        .arProt  (arProt),
        .arValid (arValid),
        .arReady (arReady),
        .rData   (rData),
        .rResp   (rResp),
        .rValid  (rValid),
        .rReady  (rReady),
`ifdef AXIL_REG_WR_PULSE_EN
        .wrPulse (wrPulse),
`endif
        .regOut  (regOut)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Transaction model: registers, pending AW/W and expected B/R responses.
    logic [31:0]         mreg [NUM_REGS];
    logic [ADDR_W-1:0]   awq [$];
    logic [35:0]         wq  [$];
    logic [1:0]          bq  [$];
    logic [33:0]         rq  [$];
    logic [NUM_REGS-1:0] exp_pulse;

    always @(negedge aclk) begin
        logic                 ar_hs, aw_hs, w_hs, b_hs, r_hs, commit;
        logic [NUM_REGS-1:0]  next_pulse;
        int                   idx;
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) mreg[i] = RESET_VAL;
            awq.delete(); wq.delete(); bq.delete(); rq.delete();
            exp_pulse = '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                chk($sformatf("model_reg%0d", i), regOut[32*i +: 32], mreg[i]);
            end
            chk("model_bvalid", {31'b0, bValid}, {31'b0, bq.size() > 0});
            chk("model_rvalid", {31'b0, rValid}, {31'b0, rq.size() > 0});
            if (bValid && bq.size() > 0) chk("model_bresp", {30'b0, bResp}, {30'b0, bq[0]});
            if (rValid && rq.size() > 0) begin
                chk("model_rdata", rData, rq[0][31:0]);
                chk("model_rresp", {30'b0, rResp}, {30'b0, rq[0][33:32]});
            end
`ifdef AXIL_REG_WR_PULSE_EN
            chk("model_wrpulse", 32'(wrPulse), 32'(exp_pulse));
`endif
            ar_hs  = arValid && arReady;
            aw_hs  = awValid && awReady;
            w_hs   = wValid && wReady;
            b_hs   = bValid && bReady;
            r_hs   = rValid && rReady;
            commit = (awq.size() > 0) && (wq.size() > 0) && (!bValid || bReady);
            next_pulse = '0;
            if (r_hs && rq.size() > 0) void'(rq.pop_front());
            if (b_hs && bq.size() > 0) void'(bq.pop_front());
            if (ar_hs) begin
                idx = int'(arAddr >> 2);
                if (idx < NUM_REGS) rq.push_back({2'b00, mreg[idx]});
                else                rq.push_back({2'b10, 32'h0});
            end
            if (commit) begin
                idx = int'(awq[0] >> 2);
                if (idx < NUM_REGS) begin
                    for (int k = 0; k < 4; k++)
                        if (wq[0][32+k]) mreg[idx][8*k +: 8] = wq[0][8*k +: 8];
                    if (wq[0][35:32] != 4'h0) next_pulse[idx] = 1'b1;
                    bq.push_back(2'b00);
                end else begin
                    bq.push_back(2'b10);
                end
                void'(awq.pop_front());
                void'(wq.pop_front());
            end
            if (aw_hs) awq.push_back(awAddr);
            if (w_hs)  wq.push_back({wStrb, wData});
            exp_pulse = next_pulse;
        end
    end

`ifdef AXIL_REG_WR_PULSE_EN
    int pulse2_cnt = 0;
    always @(negedge aclk) if (!areset && wrPulse[2]) pulse2_cnt++;
`endif

    task automatic send_aw(input logic [ADDR_W-1:0] a, input int dly);
        int n;
        @(posedge aclk);
        repeat (dly) @(posedge aclk);
        #1; awAddr = a; awValid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!awReady && n < 200);
        if (!awReady) fail_timeout("aw_handshake");
        @(posedge aclk); #1 awValid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n;
        @(posedge aclk);
        repeat (dly) @(posedge aclk);
        #1; wData = d; wStrb = s; wValid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!wReady && n < 200);
        if (!wReady) fail_timeout("w_handshake");
        @(posedge aclk); #1 wValid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bValid && n < 200);
        if (!bValid) fail_timeout("b_wait");
        resp = bResp;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(posedge aclk);
        #1; arAddr = a; arValid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!arReady && n < 200);
        if (!arReady) fail_timeout("ar_handshake");
        @(posedge aclk); #1 arValid = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!rValid && n < 200);
        if (!rValid) fail_timeout("r_wait");
        d = rData;
        r = rResp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [1:0]  br;
        int          p0;
        areset = 1'b1;
        awAddr = '0; awProt = 3'b0; awValid = 1'b0;
        wData = '0; wStrb = 4'h0; wValid = 1'b0; bReady = 1'b1;
        arAddr = '0; arProt = 3'b0; arValid = 1'b0; rReady = 1'b1;
        p0 = 0;

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_awready", {31'b0, awReady}, 32'h0);
        chk("rst_wready",  {31'b0, wReady},  32'h0);
        chk("rst_arready", {31'b0, arReady}, 32'h0);
        chk("rst_bvalid",  {31'b0, bValid},  32'h0);
        chk("rst_rvalid",  {31'b0, rValid},  32'h0);
        chk("rst_rdata",   rData, 32'h0);
        chk("rst_reg2",    regOut[95:64], 32'h0);
        @(posedge aclk); #1 areset = 1'b0;
        repeat (3) @(negedge aclk);
        chk("idle_awready", {31'b0, awReady}, 32'h1);
        chk("idle_wready",  {31'b0, wReady},  32'h1);
        chk("idle_arready", {31'b0, arReady}, 32'h1);

        // Full write to 0x008 with AW and W together; latency of regOut/bValid
        @(posedge aclk); #1;
        awAddr = 12'h008; awValid = 1'b1;
        wData = 32'h1234_5678; wStrb = 4'hF; wValid = 1'b1;
        @(negedge aclk);
        chk("t1_awready", {31'b0, awReady}, 32'h1);
        chk("t1_wready",  {31'b0, wReady},  32'h1);
        @(posedge aclk); #1 awValid = 1'b0; wValid = 1'b0;
        @(negedge aclk);
        chk("t1_reg2_n1",   regOut[95:64], 32'h0);
        chk("t1_bvalid_n1", {31'b0, bValid}, 32'h0);
        @(negedge aclk);
        chk("t1_reg2_n2",   regOut[95:64], 32'h1234_5678);
        chk("t1_bvalid_n2", {31'b0, bValid}, 32'h1);
        chk("t1_bresp",     {30'b0, bResp}, 32'h0);
        do_read(12'h008, rd, rr);
        chk("t1_rdata", rd, 32'h1234_5678);
        chk("t1_rresp", {30'b0, rr}, 32'h0);

        // Byte-strobe merge into reg 2
`ifdef AXIL_REG_WR_PULSE_EN
        p0 = pulse2_cnt;
`endif
        fork
            send_aw(12'h008, 0);
            send_w(32'hAABB_CCDD, 4'b0101, 0);
        join
        wait_b(br);
        chk("t2_bresp", {30'b0, br}, 32'h0);
        chk("t2_reg2", regOut[95:64], 32'h12BB_56DD);
        repeat (3) @(negedge aclk);
`ifdef AXIL_REG_WR_PULSE_EN
        chk("t2_pulse2_count", 32'(pulse2_cnt - p0), 32'h1);
`endif

        // W before AW, then AW before W, under B back-pressure
        @(posedge aclk); #1 bReady = 1'b0;
        fork
            send_w(32'hCAFE_0001, 4'hF, 0);
            send_aw(12'h00C, 3);
        join
        wait_b(br);
        chk("t3_bresp1", {30'b0, br}, 32'h0);
        fork
            send_aw(12'h010, 0);
            send_w(32'hCAFE_0002, 4'hF, 3);
        join
        repeat (3) begin
            @(negedge aclk);
            chk("t3_bvalid_held", {31'b0, bValid}, 32'h1);
            chk("t3_reg3", regOut[127:96], 32'hCAFE_0001);
            chk("t3_reg4_unchanged", regOut[159:128], 32'h0);
        end
        @(posedge aclk); #1 bReady = 1'b1;
        repeat (3) @(negedge aclk);
        chk("t3_reg4", regOut[159:128], 32'hCAFE_0002);
        chk("t3_bvalid_done", {31'b0, bValid}, 32'h0);

        // Out-of-range address 0x040
        fork
            send_aw(12'h040, 0);
            send_w(32'hDEAD_BEEF, 4'hF, 0);
        join
        wait_b(br);
        chk("t4_bresp", {30'b0, br}, 32'h2);
        do_read(12'h040, rd, rr);
        chk("t4_rdata", rd, 32'h0);
        chk("t4_rresp", {30'b0, rr}, 32'h2);

        // Read of reg 3 in the same cycle as its commit, then rReady back-pressure
        fork
            send_aw(12'h00C, 0);
            send_w(32'h0000_0000, 4'hF, 0);
        join
        wait_b(br);
        repeat (2) @(negedge aclk);
        @(posedge aclk); #1;
        awAddr = 12'h00C; awValid = 1'b1;
        wData = 32'hFFFF_FFFF; wStrb = 4'hF; wValid = 1'b1;
        @(negedge aclk);
        chk("t5_awready", {31'b0, awReady}, 32'h1);
        chk("t5_wready",  {31'b0, wReady},  32'h1);
        @(posedge aclk); #1;
        awValid = 1'b0; wValid = 1'b0;
        arAddr = 12'h00C; arValid = 1'b1; rReady = 1'b0;
        @(negedge aclk);
        chk("t5_arready", {31'b0, arReady}, 32'h1);
        @(posedge aclk); #1 arValid = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            chk("t5_rvalid_held", {31'b0, rValid}, 32'h1);
            chk("t5_rdata_old",   rData, 32'h0);
            chk("t5_arready_low", {31'b0, arReady}, 32'h0);
        end
        @(posedge aclk); #1 rReady = 1'b1;
        do_read(12'h00C, rd, rr);
        chk("t5_rdata_new", rd, 32'hFFFF_FFFF);

        // Reset while AW is held and a read response is outstanding
        send_aw(12'h014, 0);
        @(posedge aclk); #1 rReady = 1'b0;
        do_read(12'h008, rd, rr);
        chk("t6_pre_rdata", rd, 32'h12BB_56DD);
        @(posedge aclk); #2 areset = 1'b1;
        #1;
        chk("t6_awready", {31'b0, awReady}, 32'h0);
        chk("t6_wready",  {31'b0, wReady},  32'h0);
        chk("t6_arready", {31'b0, arReady}, 32'h0);
        chk("t6_rvalid",  {31'b0, rValid},  32'h0);
        chk("t6_rdata",   rData, 32'h0);
        chk("t6_bvalid",  {31'b0, bValid},  32'h0);
        for (int i = 0; i < NUM_REGS; i++) chk($sformatf("t6_reg%0d", i), regOut[32*i +: 32], RESET_VAL);
        repeat (2) @(negedge aclk);
        @(posedge aclk); #1 areset = 1'b0; rReady = 1'b1;
        send_w(32'h5555_5555, 4'hF, 0);
        repeat (5) begin
            @(negedge aclk);
            chk("t6_no_bvalid", {31'b0, bValid}, 32'h0);
            chk("t6_reg5", regOut[191:160], RESET_VAL);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
